// File: rtl/sdram_sched_pkg.sv
// Shared constants and FSM encoding for the SDRAM port scheduler.
// Port 0 is the audio (I2S) requester; the rest share a round-robin slot.
package sdram_sched_pkg;

  localparam int ADDR_W = 22;
  localparam int DATA_W = 128;
  localparam int BE_W   = 16;

  localparam int N_CLIENTS_DEF   = 4;
  localparam int AGE_LIMIT_DEF   = 16;
  localparam int ACK_TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } sched_state_e;

endpackage

// File: rtl/sdram_port_scheduler_rr_picker.sv
// Combinational round-robin selection over ports 1..N-1, scanning from ptr
// upward and wrapping back to port 1; port 0 is never considered here.
module rr_picker #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  // First requesting port at or after ptr, wrapping within 1..N-1
  always_comb begin
    int   cand;
    logic hit;
    valid = 1'b0;
    idx   = {IDX_W{1'b0}};
    cand  = 0;
    hit   = 1'b0;
    for (int k = 0; k < N - 1; k++) begin
      cand  = int'(ptr) + k;
      cand  = (cand > N - 1) ? cand - (N - 1) : cand;
      hit   = !valid && req[IDX_W'(cand)];
      idx   = hit ? IDX_W'(cand) : idx;
      valid = valid | hit;
    end
  end

endmodule

// File: rtl/sdram_port_scheduler.sv
// Arbitrates N_CLIENTS requesters onto a single SDRAM bridge: port 0 has
// priority bounded by an age counter, the others are served round-robin.
module sdram_port_scheduler
  import sdram_sched_pkg::*;
#(
  parameter int N_CLIENTS   = N_CLIENTS_DEF,
  parameter int AGE_LIMIT   = AGE_LIMIT_DEF,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [N_CLIENTS-1:0]             cl_req,
  input  logic [N_CLIENTS-1:0]             cl_wr,
  input  logic [N_CLIENTS-1:0][ADDR_W-1:0] cl_addr,
  input  logic [N_CLIENTS-1:0][DATA_W-1:0] cl_wrdata,
  input  logic [N_CLIENTS-1:0][BE_W-1:0]   cl_be,
  output logic [N_CLIENTS-1:0]             cl_ac,
  output logic [N_CLIENTS-1:0]             cl_wait,
  output logic [DATA_W-1:0]                cl_rddata,
  output logic [ADDR_W-1:0]                bridge_addr,
  output logic [BE_W-1:0]                  bridge_be,
  output logic                             bridge_read,
  output logic                             bridge_write,
  output logic [DATA_W-1:0]                bridge_wrdata,
  input  logic                             bridge_ack,
  input  logic [DATA_W-1:0]                bridge_rddata,
  output logic                             timeout_err
);

  localparam int IDX_W = (N_CLIENTS > 2) ? $clog2(N_CLIENTS) : 1;
  localparam int AGE_W = $clog2(AGE_LIMIT + 1);
  localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

  sched_state_e     state_r;
  logic [IDX_W-1:0] grant_r;
  logic [IDX_W-1:0] rr_ptr_r;
  logic [AGE_W-1:0] age_r;
  logic [TMO_W-1:0] tmo_cnt_r;

  logic             others_req_s;
  logic             age_full_s;
  logic             rr_valid_s;
  logic [IDX_W-1:0] rr_idx_s;
  logic             pick_valid_s;
  logic [IDX_W-1:0] pick_idx_s;
  logic             ack_s;
  logic             tmo_hit_s;

  rr_picker #(
    .N     (N_CLIENTS),
    .IDX_W (IDX_W)
  ) u_rr_picker (
    .req   (cl_req),
    .ptr   (rr_ptr_r),
    .valid (rr_valid_s),
    .idx   (rr_idx_s)
  );

  assign others_req_s = |cl_req[N_CLIENTS-1:1];
  assign age_full_s   = (age_r == AGE_W'(AGE_LIMIT));
  assign ack_s        = (state_r == ST_BUSY) && bridge_ack;
  // An ack in the final allowed BUSY cycle still completes normally
  assign tmo_hit_s    = (state_r == ST_BUSY) && !bridge_ack &&
                        (tmo_cnt_r == TMO_W'(ACK_TIMEOUT - 1));

  // Winner selection: port 0 unless it has starved the others long enough
  always_comb begin
    pick_valid_s = 1'b0;
    pick_idx_s   = {IDX_W{1'b0}};
    if (cl_req[0] && !(others_req_s && age_full_s)) begin
      pick_valid_s = 1'b1;
      pick_idx_s   = {IDX_W{1'b0}};
    end else if (rr_valid_s) begin
      pick_valid_s = 1'b1;
      pick_idx_s   = rr_idx_s;
    end else begin
      pick_valid_s = 1'b0;
      pick_idx_s   = {IDX_W{1'b0}};
    end
  end

  // Completion pulse routed to the granted port only
  always_comb begin
    cl_ac = {N_CLIENTS{1'b0}};
    for (int i = 0; i < N_CLIENTS; i++) begin
      cl_ac[i] = ack_s && (grant_r == IDX_W'(i));
    end
  end

  assign cl_wait   = cl_req & ~cl_ac;
  assign cl_rddata = bridge_rddata;

  // Scheduler FSM, latched bridge command, age/round-robin/timeout bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      grant_r       <= {IDX_W{1'b0}};
      rr_ptr_r      <= IDX_W'(1);
      age_r         <= {AGE_W{1'b0}};
      tmo_cnt_r     <= {TMO_W{1'b0}};
      timeout_err   <= 1'b0;
      bridge_read   <= 1'b0;
      bridge_write  <= 1'b0;
      bridge_addr   <= {ADDR_W{1'b0}};
      bridge_be     <= {BE_W{1'b0}};
      bridge_wrdata <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pick_valid_s) begin
            state_r       <= ST_BUSY;
            grant_r       <= pick_idx_s;
            tmo_cnt_r     <= {TMO_W{1'b0}};
            bridge_addr   <= cl_addr[pick_idx_s];
            bridge_be     <= cl_be[pick_idx_s];
            bridge_wrdata <= cl_wrdata[pick_idx_s];
            bridge_read   <= !cl_wr[pick_idx_s];
            bridge_write  <= cl_wr[pick_idx_s];
            if (pick_idx_s == {IDX_W{1'b0}}) begin
              if (others_req_s && !age_full_s) begin
                age_r <= age_r + AGE_W'(1);
              end else begin
                age_r <= age_r;
              end
            end else begin
              age_r    <= {AGE_W{1'b0}};
              rr_ptr_r <= (pick_idx_s == IDX_W'(N_CLIENTS - 1)) ? IDX_W'(1)
                                                                : pick_idx_s + IDX_W'(1);
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (bridge_ack || tmo_hit_s) begin
            state_r      <= ST_RELEASE;
            bridge_read  <= 1'b0;
            bridge_write <= 1'b0;
            tmo_cnt_r    <= {TMO_W{1'b0}};
            if (tmo_hit_s) begin
              timeout_err <= 1'b1;
            end else begin
              timeout_err <= timeout_err;
            end
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
          end
        end
        ST_RELEASE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r      <= ST_IDLE;
          bridge_read  <= 1'b0;
          bridge_write <= 1'b0;
        end
      endcase
    end
  end

endmodule
